relay_bank: RTL and testbench
=============================

# relay_bank

Host-writable relay state register bank that feeds the parallel `data` input of the TPIC serializer (mem2tpic). Byte writes land in a shadow copy. A commit request copies the shadow to the active word on the serializer's next frame boundary, so the `applied` pulse identifies exactly which frame carries the new relay pattern. A commit watchdog forces all relays off if the host goes silent.

## Interface
Parameters:
- `WIDTH`, 16: relay word width. Must be a multiple of 8 and ≥ 8.
- `ADDR_W`, 6: host address width. Must satisfy 2·(WIDTH/8)+1 ≤ 2^ADDR_W.
- `WDT_CYCLES`, 32'd50_000_000: commit watchdog timeout in clk cycles. 0 disables the watchdog.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: host byte write strobe.
- `rd_en` in 1: host byte read strobe.
- `addr` in ADDR_W: host byte address.
- `wdata` in 8: host write byte.
- `rdata` out 8: read byte, valid when `rd_valid` is high.
- `rd_valid` out 1: one-cycle read acknowledge.
- `commit` in 1: pulse requesting shadow→active transfer.
- `frame_done` in 1: serializer end-of-frame pulse (tie to `rck`).
- `data` out WIDTH: active relay word to the serializer.
- `busy` out 1: commit pending.
- `applied` out 1: one-cycle pulse when `data` updates from a commit.
- `wdt_trip` out 1: sticky flag, watchdog has forced `data` to zero.

## Operation
- NB = WIDTH/8. Address map:
  - 0..NB-1: shadow bytes, byte k = bits [8k+7:8k].
  - NB..2NB-1: active bytes, read-only.
  - 2NB: status byte = {6'b0, wdt_trip, busy}, read-only.
- Writes to read-only or out-of-range addresses are ignored. Reads of out-of-range addresses return 8'h00.
- Commit FSM, two states:
  - S_IDLE: `commit`=1 → S_PEND.
  - S_PEND: `frame_done`=1 → copy shadow to `data`, pulse `applied`, clear `wdt_trip`, → S_IDLE. `commit`=1 in S_PEND merges into the pending request (no second transfer).
- `busy` = (state == S_PEND), registered.
- Watchdog:
  - Counter clears on every `commit` and increments otherwise, saturating at WDT_CYCLES.
  - On the cycle it reaches WDT_CYCLES: `data` ← 0, `wdt_trip` ← 1, FSM → S_IDLE (pending commit cancelled), no `applied` pulse.
  - Shadow is untouched by a trip.
  - When the trip has fired and no `commit` has occurred since, the counter stays saturated and does not trip again.

## Timing
- Reset values: `data`=0, shadow=0, `rdata`=8'h00, `rd_valid`=0, `busy`=0, `applied`=0, `wdt_trip`=0, FSM=S_IDLE, watchdog counter=0.
- Write: shadow updates at the rising edge where `wr_en`=1.
- Read: `rdata`/`rd_valid` are registered, with 1-cycle latency. `rd_valid` goes high for one cycle.
- Simultaneous events:
  - `rd_en` and `wr_en` to the same byte in the same cycle: the read returns the old value.
  - `commit` and `frame_done` in the same cycle while in S_IDLE: enter S_PEND only. Transfer happens on the next `frame_done`.
  - A write in the same cycle as the transfer is not included. The copy uses the pre-edge shadow.
  - Watchdog trip and `frame_done` in S_PEND in the same cycle: the trip wins. `data`=0, no `applied`.
  - `commit` in the trip cycle: the counter clears and the trip is suppressed.
- `applied` and the `data` update occur on the same edge, which is the cycle after `frame_done`. The serializer's next frame load samples the new word.
- `reset` mid-frame: all state returns to reset values on the next edge, regardless of FSM state.

## Structure
- Shared package `relay_pkg`:
  - FSM state localparams S_IDLE/S_PEND.
  - Address-map offset helpers (SHADOW_BASE=0, ACTIVE_BASE=NB, STATUS_ADDR=2NB).
  - Status bit positions.
- One sub-module, `relay_wdt`: saturating timeout counter with `clr` and `en` inputs and a one-cycle `expire` output. WDT_CYCLES=0 ties `expire` low.
- Register file, read mux and FSM live in `relay_bank`.

## Test plan
- Reset, then read addresses 0..2NB (WIDTH=16) → every read returns 8'h00 one cycle after `rd_en`. `data`=16'h0000.
- Write 0x55 to addr 0 and 0xAA to addr 1. Pulse `commit`. Pulse `frame_done` 10 cycles later → `busy` is high until the transfer, `data`=16'hAA55 and `applied` is high exactly on the cycle after `frame_done`. Read addr 2 → 0x55.
- `commit` and `frame_done` in the same cycle → no transfer. The next `frame_done` transfers, with exactly one `applied` pulse. A second `commit` while pending → still exactly one `applied` pulse.
- Write to addr 3 (active) and addr 63 → `data` unchanged. Read addr 63 → 0x00. Read addr 4 → status byte.
- WDT_CYCLES=100, `data`=16'hAA55, no commit → after 100 cycles `data`=0 and `wdt_trip`=1 with no `applied`. Shadow still reads 0x55/0xAA. A subsequent `commit` plus `frame_done` restores 16'hAA55 and clears `wdt_trip`.
- Assert `reset` while in S_PEND with `data`≠0 → all outputs reach their reset values after one edge. A following `frame_done` causes no transfer.

Source files
------------

// File: rtl/relay_pkg.sv
// relay_bank shared definitions: FSM states, address map helpers,
// and status byte layout.
package relay_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    localparam int SHADOW_BASE = 0;

    localparam int ST_BUSY = 0;
    localparam int ST_WDT  = 1;

    function automatic int active_base(input int nb);
        return nb;
    endfunction

    function automatic int status_addr(input int nb);
        return 2 * nb;
    endfunction

    function automatic logic [7:0] status_byte(
        input logic trip,
        input logic busy
    );
        logic [7:0] s;
        s          = 8'h00;
        s[ST_WDT]  = trip;
        s[ST_BUSY] = busy;
        return s;
    endfunction

endpackage

// File: rtl/relay_wdt.sv
// Saturating commit watchdog; expire pulses once on the cycle the
// count reaches WDT_CYCLES and stays quiet until the next clr.
module relay_wdt #(
    parameter logic [31:0] WDT_CYCLES = 32'd50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [31:0] r_cnt;
    logic        w_enabled;

    assign w_enabled = (WDT_CYCLES != 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 32'd0;
        end else if (clr) begin
            r_cnt <= 32'd0;
        end else if (en && (r_cnt != WDT_CYCLES)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // A clear in the would-be trip cycle suppresses the trip.
    assign expire = w_enabled && en && !clr
                    && (r_cnt == WDT_CYCLES - 32'd1);

endmodule

// File: rtl/relay_bank.sv
// Host relay register bank: shadow bytes, frame-aligned commit to the
// active serializer word, and a watchdog that drops all relays.
module relay_bank
    import relay_pkg::*;
#(
    parameter int          WIDTH      = 16,
    parameter int          ADDR_W     = 6,
    parameter logic [31:0] WDT_CYCLES = 32'd50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              rd_valid,
    input  logic              commit,
    input  logic              frame_done,
    output logic [WIDTH-1:0]  data,
    output logic              busy,
    output logic              applied,
    output logic              wdt_trip
);

    localparam int NB = WIDTH / 8;
    localparam logic [ADDR_W-1:0] A_STATUS =
        ADDR_W'(status_addr(NB));

    state_t           r_state;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_data;
    logic [7:0]       r_rdata;
    logic             r_rd_valid;
    logic             r_applied;
    logic             r_wdt_trip;
    logic             w_expire;
    logic [7:0]       w_rbyte;

    relay_wdt #(
        .WDT_CYCLES(WDT_CYCLES)
    ) u_wdt (
        .clk   (clk),
        .reset (reset),
        .clr   (commit),
        .en    (1'b1),
        .expire(w_expire)
    );

    always_comb begin
        w_rbyte = 8'h00;
        for (int k = 0; k < NB; k++) begin
            if (addr == ADDR_W'(SHADOW_BASE + k)) begin
                w_rbyte = r_shadow[8*k +: 8];
            end
            if (addr == ADDR_W'(active_base(NB) + k)) begin
                w_rbyte = r_data[8*k +: 8];
            end
        end
        if (addr == A_STATUS) begin
            w_rbyte = status_byte(r_wdt_trip, r_state == S_PEND);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (addr == ADDR_W'(SHADOW_BASE + k)) begin
                    r_shadow[8*k +: 8] <= wdata;
                end
            end
        end
    end

    // Read sees pre-edge state, so a same-cycle write returns old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata    <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rdata <= w_rbyte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_applied  <= 1'b0;
            r_wdt_trip <= 1'b0;
        end else begin
            r_applied <= 1'b0;
            if (w_expire) begin
                r_data     <= '0;
                r_wdt_trip <= 1'b1;
                r_state    <= S_IDLE;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (commit) begin
                            r_state <= S_PEND;
                        end
                    end
                    S_PEND: begin
                        if (frame_done) begin
                            r_data     <= r_shadow;
                            r_applied  <= 1'b1;
                            r_wdt_trip <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign rdata    = r_rdata;
    assign rd_valid = r_rd_valid;
    assign data     = r_data;
    assign busy     = (r_state == S_PEND);
    assign applied  = r_applied;
    assign wdt_trip = r_wdt_trip;

endmodule

// File: tb/tb_relay_bank.sv
// Scoreboard bench for relay_bank: directed scenarios then random
// traffic, checked cycle by cycle against a byte-level model.
module tb_relay_bank;

    localparam int WDT = 100;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic        rd_en;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rd_valid;
    logic        commit;
    logic        frame_done;
    logic [15:0] data;
    logic        busy;
    logic        applied;
    logic        wdt_trip;

    relay_bank #(
        .WIDTH     (16),
        .ADDR_W    (6),
        .WDT_CYCLES(32'd100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rd_valid  (rd_valid),
        .commit    (commit),
        .frame_done(frame_done),
        .data      (data),
        .busy      (busy),
        .applied   (applied),
        .wdt_trip  (wdt_trip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rv;
        logic [7:0]  rd;
        logic [15:0] dat;
        logic        bsy;
        logic        app;
        logic        trip;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state: bytes, a pending flag, cycles since commit.
    logic [7:0]  m_sh[2];
    logic [15:0] m_act;
    bit          m_pend;
    bit          m_trip;
    int          m_since;
    logic [7:0]  m_rdata;
    bit          m_rv;
    bit          m_app;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    task automatic step(input bit rst, input bit wr, input bit rd,
                        input logic [5:0] a, input logic [7:0] wd,
                        input bit cm, input bit fd);
        exp_t       e;
        logic [7:0] v;
        bit         fire;
        @(negedge clk);
        reset      = rst;
        wr_en      = wr;
        rd_en      = rd;
        addr       = a;
        wdata      = wd;
        commit     = cm;
        frame_done = fd;
        if (rst) begin
            m_sh[0] = 8'h00;
            m_sh[1] = 8'h00;
            m_act   = 16'h0000;
            m_pend  = 0;
            m_trip  = 0;
            m_since = 0;
            m_rdata = 8'h00;
            m_rv    = 0;
            m_app   = 0;
        end else begin
            v = 8'h00;
            if (a < 2) v = m_sh[a[0]];
            else if (a < 4) v = m_act[8*a[0] +: 8];
            else if (a == 4) v = {6'b0, m_trip, m_pend};
            m_rv = rd;
            if (rd) m_rdata = v;
            fire = 0;
            if (cm) begin
                m_since = 0;
            end else if (m_since < WDT) begin
                m_since++;
                fire = (m_since == WDT);
            end
            m_app = 0;
            if (fire) begin
                m_act  = 16'h0000;
                m_trip = 1;
                m_pend = 0;
            end else if (m_pend) begin
                if (fd) begin
                    m_act  = {m_sh[1], m_sh[0]};
                    m_app  = 1;
                    m_trip = 0;
                    m_pend = 0;
                end
            end else if (cm) begin
                m_pend = 1;
            end
            if (wr && a < 2) m_sh[a[0]] = wd;
        end
        e.rv   = m_rv;
        e.rd   = m_rdata;
        e.dat  = m_act;
        e.bsy  = m_pend;
        e.app  = m_app;
        e.trip = m_trip;
        sbq.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 6'd0, 8'h00, 0, 0);
    endtask
    task automatic t_wr(input logic [5:0] a, input logic [7:0] d);
        step(0, 1, 0, a, d, 0, 0);
    endtask
    task automatic t_rd(input logic [5:0] a);
        step(0, 0, 1, a, 8'h00, 0, 0);
    endtask
    task automatic t_cm();
        step(0, 0, 0, 6'd0, 8'h00, 1, 0);
    endtask
    task automatic t_fd();
        step(0, 0, 0, 6'd0, 8'h00, 0, 1);
    endtask

    // Direct look at the DUT after the edge applying the last step.
    task automatic look();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("rd_valid", 32'(rd_valid), 32'(e.rv));
                chk("rdata", 32'(rdata), 32'(e.rd));
                chk("data", 32'(data), 32'(e.dat));
                chk("busy", 32'(busy), 32'(e.bsy));
                chk("applied", 32'(applied), 32'(e.app));
                chk("wdt_trip", 32'(wdt_trip), 32'(e.trip));
            end
        end
    end

    initial begin : driver
        reset      = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        addr       = 6'd0;
        wdata      = 8'h00;
        commit     = 1'b0;
        frame_done = 1'b0;

        step(1, 0, 0, 6'd0, 8'h00, 0, 0);
        step(1, 0, 0, 6'd0, 8'h00, 0, 0);
        for (int a = 0; a <= 4; a++) t_rd(6'(a));
        idle();

        t_wr(6'd0, 8'h55);
        t_wr(6'd1, 8'hAA);
        t_cm();
        repeat (10) idle();
        t_fd();
        look();
        chk("commit_data", 32'(data), 32'h0000_AA55);
        chk("commit_applied", 32'(applied), 32'd1);
        t_rd(6'd2);
        idle();

        step(0, 0, 0, 6'd0, 8'h00, 1, 1);
        repeat (3) idle();
        t_fd();
        idle();
        t_cm();
        idle();
        t_cm();
        idle();
        t_fd();
        idle();

        t_wr(6'd3, 8'h12);
        t_wr(6'd63, 8'h34);
        t_rd(6'd63);
        t_rd(6'd4);
        step(0, 1, 1, 6'd0, 8'h77, 0, 0);
        t_wr(6'd0, 8'h55);
        look();
        chk("ro_data", 32'(data), 32'h0000_AA55);

        t_cm();
        repeat (99) idle();
        t_cm();
        idle();
        look();
        chk("trip_suppressed", 32'(wdt_trip), 32'd0);
        repeat (98) idle();
        t_fd();
        look();
        chk("trip_flag", 32'(wdt_trip), 32'd1);
        chk("trip_data", 32'(data), 32'd0);
        chk("trip_no_applied", 32'(applied), 32'd0);
        repeat (10) idle();
        t_rd(6'd0);
        t_rd(6'd1);
        t_rd(6'd4);
        t_cm();
        repeat (3) idle();
        t_fd();
        look();
        chk("restore_data", 32'(data), 32'h0000_AA55);
        chk("restore_trip", 32'(wdt_trip), 32'd0);

        t_wr(6'd0, 8'h0F);
        t_cm();
        idle();
        step(1, 0, 0, 6'd0, 8'h00, 0, 0);
        look();
        chk("reset_data", 32'(data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        t_fd();
        look();
        chk("reset_no_xfer", 32'(applied), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                             : 6'($urandom_range(0, 5)),
                 8'($urandom),
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) == 0);
        end
        idle();

        for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, need 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
